// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug monitor Avalon-MM bridge.
//   - jdo field positions used to decode the debug command word
//   - FSM state encoding for the bridge transfer engine
package nios2_debug_pkg;

    // jdo[35] requests an immediate read after an address load.
    localparam int unsigned JDO_RDNOW_BIT = 35;
    // Write data occupies jdo[34:3].
    localparam int unsigned JDO_WDATA_HI  = 34;
    localparam int unsigned JDO_WDATA_LO  = 3;
    // Word address starts at jdo[2] and spans ADDR_W bits.
    localparam int unsigned JDO_ADDR_LO   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/nios2_debug_mon_avm_bridge_if.sv
// Avalon-MM single-word master bus used by the debug monitor bridge.
//   address     byte address, [1:0] always zero
//   read/write  transfer strobes, held until waitrequest is low
//   writedata   write payload
//   byteenable  lane enables
//   readdata    read payload, valid when read & !waitrequest
//   waitrequest slave stall
interface nios2_debug_mon_avm_bridge_if #(
    parameter int unsigned ADDR_W = 30
);
    logic [ADDR_W+1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/nios2_debug_mon_timeout.sv
// Stall timeout counter for one bus transfer.
//   clk, reset  system clock, synchronous active-high reset
//   clear_i     restart the count (new transfer)
//   en_i        cycle is a stalled strobe cycle
//   expired_o   this stalled cycle is the TIMEOUT_CYC-th one; abort the transfer
module nios2_debug_mon_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of stalled cycles already seen, so the abort lands
    // on the edge that closes the TIMEOUT_CYC-th stalled cycle.
    assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nios2_debug_mon_avm_bridge.sv
// Executes the Nios II debug slave command stream as single-word Avalon-MM transfers.
//   clk, reset               system clock, synchronous active-high reset
//   jdo                      debug command word, valid with any take_* pulse
//   take_action_ocimem_a     load address, optionally read immediately
//   take_no_action_ocimem_a  read at current address, then increment
//   take_action_ocimem_b     write jdo data at current address, then increment
//   MonDReg                  last read data / echoed write data
//   monitor_ready            idle, MonDReg valid
//   monitor_error            sticky error (timeout or overrun), cleared by ocimem_a
//   avm                      Avalon-MM master port
module nios2_debug_mon_avm_bridge
    import nios2_debug_pkg::*;
#(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [37:0]                   jdo,
    input  logic                          take_action_ocimem_a,
    input  logic                          take_no_action_ocimem_a,
    input  logic                          take_action_ocimem_b,
    output logic [31:0]                   MonDReg,
    output logic                          monitor_ready,
    output logic                          monitor_error,
    nios2_debug_mon_avm_bridge_if.master  avm
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expired;
    logic              any_take;
    logic              unused_jdo;

    // Not every jdo bit is a field for every ADDR_W.
    assign unused_jdo = ^jdo;

    assign any_take = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign tmo_en   = (rd_q | wr_q) & avm.waitrequest;

    nios2_debug_mon_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mon_d   = mon_q;
        ready_d = ready_q;
        err_d   = err_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        tmo_clr = 1'b0;

        case (state_q)
            IDLE: begin
                // Coincident pulses: ocimem_a, then ocimem_b, then no_action_a.
                if (take_action_ocimem_a) begin
                    addr_d = jdo[JDO_ADDR_LO +: ADDR_W];
                    err_d  = 1'b0;
                    if (jdo[JDO_RDNOW_BIT]) begin
                        rd_d    = 1'b1;
                        ready_d = 1'b0;
                        tmo_clr = 1'b1;
                        state_d = RD;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
                    mon_d   = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
                    wr_d    = 1'b1;
                    ready_d = 1'b0;
                    tmo_clr = 1'b1;
                    state_d = WR;
                end else if (take_no_action_ocimem_a) begin
                    rd_d    = 1'b1;
                    ready_d = 1'b0;
                    tmo_clr = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                if (any_take) begin
                    err_d = 1'b1;
                end
                if (!avm.waitrequest) begin
                    mon_d   = avm.readdata;
                    addr_d  = addr_q + ADDR_W'(1);
                    rd_d    = 1'b0;
                    state_d = DONE;
                end else if (tmo_expired) begin
                    // Abort: keep MonDReg and address so the host can retry.
                    rd_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WR: begin
                if (any_take) begin
                    err_d = 1'b1;
                end
                if (!avm.waitrequest) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    wr_d    = 1'b0;
                    state_d = DONE;
                end else if (tmo_expired) begin
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (any_take) begin
                    err_d = 1'b1;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mon_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign MonDReg        = mon_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = err_q;
    assign avm.address    = {addr_q, 2'b00};
    assign avm.read       = rd_q;
    assign avm.write      = wr_q;
    assign avm.writedata  = wdata_q;
    assign avm.byteenable = 4'hF;
endmodule

// File: tb/tb_nios2_debug_mon_avm_bridge.sv
module tb_nios2_debug_mon_avm_bridge;
    localparam int unsigned ADDR_W      = 30;
    localparam int unsigned TIMEOUT_CYC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_na, take_b;
    logic [31:0] mon;
    logic        ready, err;

    int total = 0;
    int bad   = 0;
    int n;

    nios2_debug_mon_avm_bridge_if #(.ADDR_W(ADDR_W)) avm ();

    nios2_debug_mon_avm_bridge #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .MonDReg                 (mon),
        .monitor_ready           (ready),
        .monitor_error           (err),
        .avm                     (avm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic rdnow, input logic [29:0] a);
        logic [37:0] j;
        j = '0;
        j[35] = rdnow;
        j[31:2] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_a = 1'b0;
        take_na = 1'b0;
        take_b = 1'b0;
        avm.readdata = '0;
        avm.waitrequest = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_mon", 64'(mon), 64'h0);
        check("rst_ready", 64'(ready), 64'h1);
        check("rst_err", 64'(err), 64'h0);
        check("rst_addr", 64'(avm.address), 64'h0);
        check("rst_rd", 64'(avm.read), 64'h0);
        check("rst_wr", 64'(avm.write), 64'h0);
        check("rst_wdata", 64'(avm.writedata), 64'h0);
        check("byteen", 64'(avm.byteenable), 64'hF);

        // Load 0x100 with immediate read, zero waitstates.
        jdo = mk_a(1'b1, 30'h100);
        take_a = 1'b1;
        avm.readdata = 32'hCAFEF00D;
        step();
        take_a = 1'b0;
        check("t1_rd_on", 64'(avm.read), 64'h1);
        check("t1_addr", 64'(avm.address), 64'h400);
        check("t1_busy", 64'(ready), 64'h0);
        step();
        check("t1_rd_off", 64'(avm.read), 64'h0);
        check("t1_mon", 64'(mon), 64'hCAFEF00D);
        check("t1_busy2", 64'(ready), 64'h0);
        step();
        check("t1_ready", 64'(ready), 64'h1);
        check("t1_err", 64'(err), 64'h0);

        // Write at auto-incremented 0x101 with 5 stall cycles.
        jdo = mk_b(32'h12345678);
        take_b = 1'b1;
        avm.waitrequest = 1'b1;
        step();
        take_b = 1'b0;
        check("t2_wdata", 64'(avm.writedata), 64'h12345678);
        check("t2_mon", 64'(mon), 64'h12345678);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (avm.write === 1'b1 && avm.address === 32'h404) n++;
            step();
        end
        avm.waitrequest = 1'b0;
        if (avm.write === 1'b1 && avm.address === 32'h404) n++;
        check("t2_held", 64'(n), 64'd6);
        step();
        check("t2_wr_off", 64'(avm.write), 64'h0);
        step();
        check("t2_ready", 64'(ready), 64'h1);

        // Confirm address advanced to 0x102.
        take_na = 1'b1;
        avm.readdata = 32'h00000102;
        step();
        take_na = 1'b0;
        check("t2_next", 64'(avm.address), 64'h408);
        step();
        step();

        // Top word address, then read and wrap.
        jdo = mk_a(1'b0, 30'h3FFFFFFF);
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        check("t3_idle_rd", 64'(avm.read), 64'h0);
        check("t3_idle_ready", 64'(ready), 64'h1);
        take_na = 1'b1;
        avm.readdata = 32'h0BADBEEF;
        step();
        take_na = 1'b0;
        check("t3_addr_top", 64'(avm.address), 64'hFFFFFFFC);
        step();
        check("t3_mon", 64'(mon), 64'h0BADBEEF);
        check("t3_wrap", 64'(avm.address), 64'h0);
        step();
        check("t3_err", 64'(err), 64'h0);

        // Stuck waitrequest: abort after TIMEOUT_CYC strobe cycles.
        jdo = mk_a(1'b1, 30'h55);
        take_a = 1'b1;
        avm.waitrequest = 1'b1;
        avm.readdata = 32'hDEADDEAD;
        step();
        take_a = 1'b0;
        n = 0;
        while (avm.read === 1'b1 && n < 50) begin
            n++;
            step();
        end
        check("t4_strobe_cyc", 64'(n), 64'(TIMEOUT_CYC));
        check("t4_err", 64'(err), 64'h1);
        check("t4_mon", 64'(mon), 64'h0BADBEEF);
        check("t4_addr_kept", 64'(avm.address), 64'h154);
        step();
        check("t4_ready", 64'(ready), 64'h1);
        avm.waitrequest = 1'b0;
        jdo = mk_a(1'b0, 30'h10);
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        check("t4_err_clr", 64'(err), 64'h0);

        // Overrun during RD stall.
        avm.waitrequest = 1'b1;
        take_na = 1'b1;
        step();
        take_na = 1'b0;
        step();
        take_na = 1'b1;
        step();
        take_na = 1'b0;
        check("t5_overrun", 64'(err), 64'h1);
        check("t5_rd_held", 64'(avm.read), 64'h1);
        check("t5_addr", 64'(avm.address), 64'h40);
        avm.waitrequest = 1'b0;
        avm.readdata = 32'h11112222;
        step();
        check("t5_mon", 64'(mon), 64'h11112222);
        step();
        check("t5_err_sticky", 64'(err), 64'h1);

        // ocimem_a and ocimem_b together: only the load happens.
        jdo = mk_a(1'b0, 30'h20);
        take_a = 1'b1;
        take_b = 1'b1;
        step();
        take_a = 1'b0;
        take_b = 1'b0;
        check("t5_both_wr", 64'(avm.write), 64'h0);
        check("t5_both_ready", 64'(ready), 64'h1);
        check("t5_both_err", 64'(err), 64'h0);
        check("t5_both_mon", 64'(mon), 64'h11112222);
        check("t5_both_addr", 64'(avm.address), 64'h80);

        // Reset during WR stall.
        avm.waitrequest = 1'b1;
        jdo = mk_b(32'hA5A5A5A5);
        take_b = 1'b1;
        step();
        take_b = 1'b0;
        check("t6_wr_on", 64'(avm.write), 64'h1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_wr_off", 64'(avm.write), 64'h0);
        check("t6_mon", 64'(mon), 64'h0);
        check("t6_ready", 64'(ready), 64'h1);
        check("t6_err", 64'(err), 64'h0);
        check("t6_addr", 64'(avm.address), 64'h0);
        check("t6_wdata", 64'(avm.writedata), 64'h0);
        avm.waitrequest = 1'b0;
        avm.readdata = 32'h76543210;
        take_na = 1'b1;
        step();
        take_na = 1'b0;
        check("t6_idle_rd", 64'(avm.read), 64'h1);
        step();
        check("t6_idle_mon", 64'(mon), 64'h76543210);
        step();
        check("t6_idle_ready", 64'(ready), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
